wb_arb_intercon: RTL

- Parametrised Wishbone interconnect.
- Arbitrates NUM_MASTERS masters round-robin and decodes one address field to select one of NUM_SLAVES slaves.
- Registers the transaction and returns a one-cycle ACK with the captured read data.
- Replaces the single-master intercon so a DMA engine (disk/UART) can share RAM and VRAM with the CPU. Unmapped addresses and, optionally, hung slaves are terminated with an error ACK.

---
 rtl/wb_arb_intercon_if.sv | 34 +++
 rtl/wb_arb_intercon.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_intercon_if.sv
// Bus bundle for wb_arb_intercon: master-side request/response plus slave-side strobe/ack.
// The interconnect uses the slave modport; masters and slave models use the master modport.
interface wb_arb_intercon_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 16,
  parameter int DW          = 32,
  parameter int AW          = 32
) ();
  logic [NUM_MASTERS-1:0]    m_stb;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [NUM_MASTERS*AW-1:0] m_addr;
  logic [NUM_MASTERS*DW-1:0] m_dat_i;
  logic [DW-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_err;
  logic [NUM_SLAVES-1:0]     s_stb;
  logic                      s_we;
  logic [AW-1:0]             s_addr;
  logic [DW-1:0]             s_dat_o;
  logic [NUM_SLAVES*DW-1:0]  s_dat_i;
  logic [NUM_SLAVES-1:0]     s_ack;
  logic [2:0]                grant;
  logic                      busy;

  modport slave (
    input  m_stb, m_we, m_addr, m_dat_i, s_dat_i, s_ack,
    output m_dat_o, m_ack, m_err, s_stb, s_we, s_addr, s_dat_o, grant, busy
  );

  modport master (
    output m_stb, m_we, m_addr, m_dat_i, s_dat_i, s_ack,
    input  m_dat_o, m_ack, m_err, s_stb, s_we, s_addr, s_dat_o, grant, busy
  );
endinterface

// File: rtl/wb_arb_intercon.sv
// Round-robin Wishbone interconnect: NUM_MASTERS masters share NUM_SLAVES address-decoded slaves.
// Define WB_TIMEOUT_EN to terminate hung slaves with an error ACK after TIMEOUT BUSY cycles.
module wb_arb_intercon #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 16,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SEL_LO      = 28,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT     = 255
) (
  input logic clk,
  input logic rstn,
  wb_arb_intercon_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d, grant_q, grant_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [DW-1:0]    wdat_q, wdat_d, rdat_q, rdat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;

`ifdef WB_TIMEOUT_EN
  localparam int TWR = $clog2(TIMEOUT + 1);
  localparam int TW  = (TWR < 8) ? 8 : ((TWR > 32) ? 32 : TWR);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  // counter holds completed BUSY cycles, so the last allowed cycle sees TIMEOUT-1
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`endif

  logic          req_any, w_we;
  logic [2:0]    win;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_dat;

  // first requester strictly after the pointer, wrapping
  always_comb begin
    req_any = 1'b0;
    win     = ptr_q;
    for (int k = 1; k <= NUM_MASTERS; k++)
      for (int i = 0; i < NUM_MASTERS; i++)
        if (!req_any && bus.m_stb[i] && ((int'(ptr_q) + k) % NUM_MASTERS) == i) begin
          req_any = 1'b1;
          win     = 3'(i);
        end
    w_addr = '0;
    w_we   = 1'b0;
    w_dat  = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (win == 3'(i)) begin
        w_addr = bus.m_addr[i*AW +: AW];
        w_we   = bus.m_we[i];
        w_dat  = bus.m_dat_i[i*DW +: DW];
      end
  end

  logic                  ack_sel;
  logic [DW-1:0]         dat_sel;
  logic [NUM_SLAVES-1:0] stb_v;

  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    stb_v   = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (sel_q == SEL_W'(s)) begin
        ack_sel  = bus.s_ack[s];
        dat_sel  = bus.s_dat_i[s*DW +: DW];
        stb_v[s] = (state_q == BUSY);
      end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
`ifdef WB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: if (req_any) begin
        ptr_d   = win;
        grant_d = win;
        addr_d  = w_addr;
        we_d    = w_we;
        wdat_d  = w_dat;
        sel_d   = w_addr[SEL_LO +: SEL_W];
        if (32'(w_addr[SEL_LO +: SEL_W]) >= 32'(NUM_SLAVES)) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          state_d = BUSY;
`ifdef WB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      BUSY: begin
        // ACK wins over a coincident timeout
        if (ack_sel) begin
          rdat_d  = dat_sel;
          state_d = DONE;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          rdat_d  = DW'(32'hDEAD_BEEF);
          state_d = DONE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 3'(NUM_MASTERS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  logic [NUM_MASTERS-1:0] ack_v, err_v;

  always_comb begin
    ack_v = '0;
    err_v = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (state_q == DONE && grant_q == 3'(i)) begin
        ack_v[i] = 1'b1;
        err_v[i] = err_q;
      end
  end

  assign bus.m_ack   = ack_v;
  assign bus.m_err   = err_v;
  assign bus.m_dat_o = rdat_q;
  assign bus.s_stb   = stb_v;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_dat_o = wdat_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
